// File: rtl/mix_round_engine_pkg.sv
// Shared definitions for the iterative mixing engine: round constants,
// multiplicative-inverse helper and the control state encoding.
package mix_pkg;

    localparam int MAX_ROUNDS = 8;

    localparam logic [63:0] X_TAB [MAX_ROUNDS] = '{
        64'h9445827458d1e38f, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1, 64'h510e527fade682d1,
        64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179, 64'hcbbb9d5dc1059ed8
    };

    localparam logic [63:0] A_TAB [MAX_ROUNDS] = '{
        64'hf053cfc591ae5a85, 64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h428a2f98d728ae22,
        64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc, 64'h3956c25bf348b538
    };

    // Multipliers must stay odd so every round is invertible modulo 2^W.
    localparam logic [63:0] M_TAB [MAX_ROUNDS] = '{
        64'hf61475c34efa5845, 64'h9e3779b97f4a7c15, 64'hbf58476d1ce4e5b9, 64'h94d049bb133111eb,
        64'hff51afd7ed558ccd, 64'hc4ceb9fe1a85ec53, 64'hd6e8feb86659fd93, 64'h2545f4914f6cdd1d
    };

    localparam int R_TAB [MAX_ROUNDS] = '{46, 13, 29, 37, 52, 7, 21, 59};

    // Newton iteration: y = m is correct to 3 bits for odd m; each step doubles that.
    function automatic logic [63:0] minv64(input logic [63:0] m);
        logic [63:0] y;
        y = m;
        for (int i = 0; i < 6; i++) begin
            y = y * (64'd2 - m * y);
        end
        return y;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mix_round.sv
// One combinational mixing round, forward or inverse, selected by round index.
module mix_round
    import mix_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [2:0]   round_i,
    input  logic         inv_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] x_tab  [MAX_ROUNDS];
    logic [W-1:0] a_tab  [MAX_ROUNDS];
    logic [W-1:0] m_tab  [MAX_ROUNDS];
    logic [W-1:0] mi_tab [MAX_ROUNDS];
    logic [6:0]   r_tab  [MAX_ROUNDS];

    // Constants are folded at elaboration; the round index only drives small muxes.
    generate
        for (genvar gi = 0; gi < MAX_ROUNDS; gi++) begin : g_tab
            localparam logic [63:0] MI = minv64(M_TAB[gi]);
            assign x_tab[gi]  = X_TAB[gi][W-1:0];
            assign a_tab[gi]  = A_TAB[gi][W-1:0];
            assign m_tab[gi]  = M_TAB[gi][W-1:0];
            assign mi_tab[gi] = MI[W-1:0];
            assign r_tab[gi]  = 7'(R_TAB[gi] % W);
        end
    endgenerate

    logic [W-1:0] x, a, m, mi;
    logic [6:0]   r;
    logic [W-1:0] f_add, f_mul, f_out;
    logic [W-1:0] i_rot, i_mul, i_out;

    assign x  = x_tab[round_i];
    assign a  = a_tab[round_i];
    assign m  = m_tab[round_i];
    assign mi = mi_tab[round_i];
    assign r  = r_tab[round_i];

    assign f_add = (data_i ^ x) + a;
    assign f_mul = f_add * m;
    assign f_out = (f_mul >> r) | (f_mul << (7'(W) - r));

    assign i_rot = (data_i << r) | (data_i >> (7'(W) - r));
    assign i_mul = i_rot * mi;
    assign i_out = (i_mul - a) ^ x;

    assign data_o = inv_i ? i_out : f_out;

endmodule

// File: rtl/mix_round_engine.sv
// Iterative back-pressured mixing engine: UNROLL rounds per clock, forward
// or inverse, with a valid/ready handshake on both sides.
module mix_round_engine
    import mix_pkg::*;
#(
    parameter int W      = 64,
    parameter int ROUNDS = 8,
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    generate
        if (W < 8 || W > 64 || ROUNDS < 1 || ROUNDS > MAX_ROUNDS ||
            UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_params
            $error("mix_round_engine: illegal W/ROUNDS/UNROLL combination");
        end
    endgenerate

    localparam int CW = $clog2(ROUNDS) + 1;
    localparam logic [CW-1:0] STEP = CW'(UNROLL);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  data_q;
    logic [W-1:0]  out_data_q;
    logic          inv_q;
    logic [W-1:0]  data_d;
    logic          last_group;

    logic [W-1:0] chain [UNROLL+1];
    assign chain[0] = data_q;

    // Inverse mode walks the same table backwards, stage by stage.
    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_stage
            logic [2:0] idx;
            assign idx = inv_q ? 3'(ROUNDS - 1 - int'(cnt_q) - gi)
                               : 3'(int'(cnt_q) + gi);
            mix_round #(.W(W)) u_round (
                .round_i (idx),
                .inv_i   (inv_q),
                .data_i  (chain[gi]),
                .data_o  (chain[gi+1])
            );
        end
    endgenerate

    assign data_d     = chain[UNROLL];
    assign last_group = (cnt_q + STEP) == LAST;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign out_data  = out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            inv_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        inv_q   <= in_inv;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    if (last_group) begin
                        out_data_q <= data_d;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + STEP;
                    end
                end
                DONE: begin
                    // Consume and accept in the same cycle for back-to-back traffic.
                    if (out_ready) begin
                        if (in_valid) begin
                            data_q  <= in_data;
                            inv_q   <= in_inv;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_round_engine.sv
// Directed bench: W=8 single-round hand vectors plus 64-bit round trips,
// unroll equivalence, back-pressure, async reset and input-change checks.
module tb_mix_round_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv [4];
    logic        ii [4];
    logic        ordy [4];
    logic [63:0] id [4];
    logic        ir [4];
    logic        ov [4];
    logic        bz [4];
    logic [63:0] od [4];
    logic [7:0]  od8;

    int n_vec = 0;
    int n_err = 0;

    assign od[0] = {56'd0, od8};

    mix_round_engine #(.W(8), .ROUNDS(1), .UNROLL(1)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][7:0]),
        .in_inv(ii[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od8), .busy(bz[0]));

    mix_round_engine #(.W(64), .ROUNDS(8), .UNROLL(1)) dut_u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_inv(ii[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1]));

    mix_round_engine #(.W(64), .ROUNDS(8), .UNROLL(2)) dut_u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_inv(ii[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bz[2]));

    mix_round_engine #(.W(64), .ROUNDS(8), .UNROLL(4)) dut_u4 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]),
        .in_inv(ii[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .busy(bz[3]));

    localparam logic [63:0] TX [8] = '{
        64'h9445827458d1e38f, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1, 64'h510e527fade682d1,
        64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179, 64'hcbbb9d5dc1059ed8};
    localparam logic [63:0] TA [8] = '{
        64'hf053cfc591ae5a85, 64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h428a2f98d728ae22,
        64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc, 64'h3956c25bf348b538};
    localparam logic [63:0] TM [8] = '{
        64'hf61475c34efa5845, 64'h9e3779b97f4a7c15, 64'hbf58476d1ce4e5b9, 64'h94d049bb133111eb,
        64'hff51afd7ed558ccd, 64'hc4ceb9fe1a85ec53, 64'hd6e8feb86659fd93, 64'h2545f4914f6cdd1d};
    localparam int TR [8] = '{46, 13, 29, 37, 52, 7, 21, 59};

    // Reference forward mix for W=64, ROUNDS=8.
    function automatic logic [63:0] fwd_model(input logic [63:0] x);
        logic [63:0]  t;
        logic [127:0] tt;
        t = x;
        for (int i = 0; i < 8; i++) begin
            t  = (t ^ TX[i]) + TA[i];
            t  = t * TM[i];
            tt = {t, t} >> (TR[i] % 64);
            t  = tt[63:0];
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int d, input string tag);
        check({tag, "_flags"}, {61'd0, ir[d], ov[d], bz[d]}, 64'b100);
        check({tag, "_out_data"}, od[d], 64'd0);
    endtask

    task automatic start(input int d, input logic [63:0] x, input logic inv, input string tag);
        iv[d] = 1'b1;
        id[d] = x;
        ii[d] = inv;
        check({tag, "_in_ready"}, 64'(ir[d]), 64'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int lat);
        for (lat = 1; lat <= 40; lat++) begin
            @(posedge clk); #1;
            if (ov[d]) break;
        end
    endtask

    task automatic consume(input int d);
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
    endtask

    task automatic txn(input int d, input logic [63:0] x, input logic inv, input int exp_lat,
                       input string tag, output logic [63:0] y);
        int lat;
        start(d, x, inv, tag);
        wait_done(d, lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        y = od[d];
        $display("txn %s dut=%0d in=%h inv=%0b out=%h latency=%0d", tag, d, x, inv, y, lat);
        consume(d);
    endtask

    initial begin
        logic [63:0] y, y2, w1, w2, w3, w4, e;
        logic [63:0] vecs [5];
        int lat;
        logic seen;

        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; ii[i] = 1'b0; ordy[i] = 1'b0; id[i] = 64'd0;
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check_reset(i, $sformatf("reset_in_%0d", i));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) check_reset(i, $sformatf("after_reset_%0d", i));

        // W=8, single round, hand-computed against round 0 constants.
        txn(0, 64'h8f, 1'b0, 1, "w8_fwd_8f", y);
        check("w8_fwd_8f_data", y, 64'h67);
        txn(0, 64'h67, 1'b1, 1, "w8_inv_67", y);
        check("w8_inv_67_data", y, 64'h8f);
        txn(0, 64'h00, 1'b0, 1, "w8_fwd_00", y);
        check("w8_fwd_00_data", y, 64'h91);
        txn(0, 64'h91, 1'b1, 1, "w8_inv_91", y);
        check("w8_inv_91_data", y, 64'h00);

        // 64-bit: model forward, round trip, and unroll equivalence.
        vecs[0] = 64'h0;
        vecs[1] = 64'hffffffffffffffff;
        vecs[2] = 64'h0123456789abcdef;
        vecs[3] = {$urandom, $urandom};
        vecs[4] = {$urandom, $urandom};
        for (int v = 0; v < 5; v++) begin
            e = fwd_model(vecs[v]);
            txn(1, vecs[v], 1'b0, 8, $sformatf("u1_fwd_%0d", v), y);
            check($sformatf("u1_fwd_%0d_data", v), y, e);
            txn(1, e, 1'b1, 8, $sformatf("u1_inv_%0d", v), y2);
            check($sformatf("u1_inv_%0d_data", v), y2, vecs[v]);
            txn(2, vecs[v], 1'b0, 4, $sformatf("u2_fwd_%0d", v), y);
            check($sformatf("u2_fwd_%0d_data", v), y, e);
            txn(2, e, 1'b1, 4, $sformatf("u2_inv_%0d", v), y2);
            check($sformatf("u2_inv_%0d_data", v), y2, vecs[v]);
            txn(3, vecs[v], 1'b0, 2, $sformatf("u4_fwd_%0d", v), y);
            check($sformatf("u4_fwd_%0d_data", v), y, e);
            txn(3, e, 1'b1, 2, $sformatf("u4_inv_%0d", v), y2);
            check($sformatf("u4_inv_%0d_data", v), y2, vecs[v]);
        end

        // Back-pressure in DONE, then consume and accept in the same cycle.
        w1 = 64'hdeadbeefcafef00d;
        w2 = 64'h1122334455667788;
        start(1, w1, 1'b0, "stall");
        wait_done(1, lat);
        check("stall_latency", 64'(lat), 64'd8);
        iv[1] = 1'b1;
        id[1] = w2;
        ii[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall_valid_%0d", c), 64'(ov[1]), 64'd1);
            check($sformatf("stall_data_%0d", c), od[1], fwd_model(w1));
            check($sformatf("stall_in_ready_%0d", c), 64'(ir[1]), 64'd0);
        end
        ordy[1] = 1'b1;
        #0;
        check("b2b_in_ready", 64'(ir[1]), 64'd1);
        @(posedge clk); #1;
        ordy[1] = 1'b0;
        iv[1] = 1'b0;
        check("b2b_busy", 64'(bz[1]), 64'd1);
        check("b2b_valid_low", 64'(ov[1]), 64'd0);
        wait_done(1, lat);
        check("b2b_latency", 64'(lat), 64'd8);
        check("b2b_data", od[1], fwd_model(w2));
        $display("txn b2b dut=1 in=%h out=%h latency=%0d", w2, od[1], lat);
        consume(1);

        // Inputs changed during RUN must not affect the result.
        w3 = 64'h0f1e2d3c4b5a6978;
        start(1, w3, 1'b0, "tog");
        iv[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            id[1] = ~w3 ^ 64'(c);
            ii[1] = ~ii[1];
            check($sformatf("tog_in_ready_%0d", c), 64'(ir[1]), 64'd0);
            check($sformatf("tog_busy_%0d", c), 64'(bz[1]), 64'd1);
            @(posedge clk); #1;
        end
        iv[1] = 1'b0;
        ii[1] = 1'b0;
        wait_done(1, lat);
        check("tog_latency", 64'(lat), 64'd5);
        check("tog_data", od[1], fwd_model(w3));
        $display("txn tog dut=1 in=%h out=%h latency=%0d", w3, od[1], lat);
        consume(1);

        // Asynchronous reset in the middle of RUN.
        w4 = 64'h5555aaaa3333cccc;
        start(1, w4, 1'b0, "arst");
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check_reset(1, "arst_mid_run");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ov[1]) seen = 1'b1;
        end
        check("arst_no_stale_valid", 64'(seen), 64'd0);
        check("arst_out_data", od[1], 64'd0);
        txn(1, w4, 1'b0, 8, "arst_after", y);
        check("arst_after_data", y, fwd_model(w4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
